// File: rtl/string_line_walker.sv
`default_nettype none
// ============================================================================
// Module  : string_line_walker
// Brief   : Bresenham line rasteriser started by a four-phase req/ack handshake.
// Revision: 1.0
// ============================================================================
module string_line_walker #(
   parameter int CW = 10
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req,
   input  logic [CW-1:0] x0,
   input  logic [CW-1:0] y0,
   input  logic [CW-1:0] x1,
   input  logic [CW-1:0] y1,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic          busy,
   output logic          ack,
   output logic [CW:0]   pix_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_WALK  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [CW-1:0]        xs_q, xs_d, ys_q, ys_d;
   logic [CW-1:0]        xe_q, xe_d, ye_q, ye_d;
   logic [CW-1:0]        px_q, px_d, py_q, py_d;
   logic signed [CW+1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
   logic                 sx_q, sx_d, sy_q, sy_d;
   logic [CW:0]          cnt_q, cnt_d;

   logic [CW-1:0]        abs_dx, abs_dy;
   logic signed [CW+2:0] e2, dx_ext, dy_ext;
   logic                 at_end;

   assign abs_dx = (xe_q >= xs_q) ? (xe_q - xs_q) : (xs_q - xe_q);
   assign abs_dy = (ye_q >= ys_q) ? (ye_q - ys_q) : (ys_q - ye_q);
   assign e2     = {err_q, 1'b0};
   assign dx_ext = {dx_q[CW+1], dx_q};
   assign dy_ext = {dy_q[CW+1], dy_q};
   assign at_end = (px_q == xe_q) && (py_q == ye_q);

   always_comb begin
      state_d = state_q;
      xs_d    = xs_q;
      ys_d    = ys_q;
      xe_d    = xe_q;
      ye_d    = ye_q;
      px_d    = px_q;
      py_d    = py_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      err_d   = err_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               xs_d    = x0;
               ys_d    = y0;
               xe_d    = x1;
               ye_d    = y1;
               cnt_d   = '0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            dx_d    = $signed({2'b00, abs_dx});
            dy_d    = -$signed({2'b00, abs_dy});
            err_d   = $signed({2'b00, abs_dx}) - $signed({2'b00, abs_dy});
            sx_d    = (xs_q < xe_q);
            sy_d    = (ys_q < ye_q);
            px_d    = xs_q;
            py_d    = ys_q;
            state_d = S_WALK;
         end
         S_WALK: begin
            if (pix_ready) begin
               cnt_d = cnt_q + (CW+1)'(1);
               if (at_end) begin
                  state_d = S_DONE;
               end else begin
                  // Both axis tests use the error value from before this step.
                  if (e2 >= dy_ext) begin
                     err_d = err_d + dy_q;
                     px_d  = sx_q ? (px_q + CW'(1)) : (px_q - CW'(1));
                  end
                  if (e2 <= dx_ext) begin
                     err_d = err_d + dx_q;
                     py_d  = sy_q ? (py_q + CW'(1)) : (py_q - CW'(1));
                  end
               end
            end
         end
         S_DONE: begin
            if (!req) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         xs_q    <= '0;
         ys_q    <= '0;
         xe_q    <= '0;
         ye_q    <= '0;
         px_q    <= '0;
         py_q    <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         err_q   <= '0;
         sx_q    <= 1'b0;
         sy_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         xs_q    <= xs_d;
         ys_q    <= ys_d;
         xe_q    <= xe_d;
         ye_q    <= ye_d;
         px_q    <= px_d;
         py_q    <= py_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         err_q   <= err_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pix_valid = (state_q == S_WALK);
   assign busy      = (state_q == S_SETUP) || (state_q == S_WALK);
   assign ack       = (state_q == S_DONE);
   assign pix_x     = px_q;
   assign pix_y     = py_q;
   assign pix_count = cnt_q;

endmodule
`default_nettype wire
